// File: rtl/apb_efpga_lint_initiator.sv
// APB slave that forwards each access as a single lint transaction to the eFPGA.
// Hung lint handshakes are aborted by a cycle timeout; an owed response is drained before the next request.
module apb_efpga_lint_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [19:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  input  logic        fpga_ready_i,
  output logic [19:0] lint_ADDR,
  output logic        lint_WEN,
  output logic        lint_REQ,
  output logic [3:0]  lint_BE,
  output logic [31:0] lint_WDATA,
  input  logic [31:0] lint_RDATA,
  input  logic        lint_GNT,
  input  logic        lint_VALID,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    REQ   = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_r, next_state_s;
  logic [15:0] cnt_r;
  logic        drain_r;
  logic        write_r;

  logic        access_s, tmo_hit_s, wr_s;
  logic        err_s, tmo_s, drain_set_s, drain_clr_s, latch_s;

  logic [31:0] prdata_d, wdata_d;
  logic [19:0] addr_d;
  logic [3:0]  be_d;
  logic        pready_d, pslverr_d, req_d, wen_d, timeout_d;

  assign access_s  = psel_i & penable_i;
  assign tmo_hit_s = (cnt_r == TMO_LAST);
  assign latch_s   = (state_r == IDLE) & access_s;
  // the access direction is not yet latched when IDLE jumps straight to DONE
  assign wr_s      = (state_r == IDLE) ? pwrite_i : write_r;

  // state, timeout counter, drain flag and latched direction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      drain_r <= 1'b0;
      write_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (((next_state_s == REQ) || (next_state_s == DRAIN)) && (next_state_s != state_r)) begin
        cnt_r <= 16'd0;
      end else if ((state_r == REQ) || (state_r == RESP) || (state_r == DRAIN)) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (drain_set_s) begin
        drain_r <= 1'b1;
      end else if (drain_clr_s) begin
        drain_r <= 1'b0;
      end else begin
        drain_r <= drain_r;
      end
      if (latch_s) begin
        write_r <= pwrite_i;
      end else begin
        write_r <= write_r;
      end
    end
  end

  // next-state decode with error, timeout and drain side conditions
  always_comb begin
    next_state_s = state_r;
    err_s        = 1'b0;
    tmo_s        = 1'b0;
    drain_set_s  = 1'b0;
    drain_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        drain_clr_s = lint_VALID;
        if (access_s) begin
          if (!fpga_ready_i) begin
            next_state_s = DONE;
            err_s        = 1'b1;
          end else if (drain_r && !lint_VALID) begin
            next_state_s = DRAIN;
          end else begin
            next_state_s = REQ;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      DRAIN: begin
        if (lint_VALID || tmo_hit_s) begin
          next_state_s = REQ;
          drain_clr_s  = 1'b1;
          tmo_s        = ~lint_VALID;
        end else begin
          next_state_s = DRAIN;
        end
      end
      REQ: begin
        if (tmo_hit_s) begin
          next_state_s = DONE;
          err_s        = 1'b1;
          tmo_s        = 1'b1;
          drain_set_s  = lint_GNT;
        end else if (lint_GNT) begin
          next_state_s = RESP;
        end else begin
          next_state_s = REQ;
        end
      end
      RESP: begin
        if (lint_VALID) begin
          next_state_s = DONE;
        end else if (tmo_hit_s) begin
          next_state_s = DONE;
          err_s        = 1'b1;
          tmo_s        = 1'b1;
          drain_set_s  = 1'b1;
        end else begin
          next_state_s = RESP;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // next values of all registered outputs
  always_comb begin
    req_d     = (next_state_s == REQ);
    pready_d  = (next_state_s == DONE);
    pslverr_d = (next_state_s == DONE) & err_s;
    timeout_d = tmo_s;
    prdata_d  = 32'd0;
    if (next_state_s == DONE) begin
      if (wr_s) begin
        prdata_d = 32'd0;
      end else if (err_s) begin
        prdata_d = ERR_RDATA;
      end else begin
        prdata_d = lint_RDATA;
      end
    end else begin
      prdata_d = 32'd0;
    end
    if (latch_s) begin
      addr_d  = paddr_i;
      wdata_d = pwdata_i;
      wen_d   = ~pwrite_i;
      be_d    = pwrite_i ? pstrb_i : 4'hF;
    end else begin
      addr_d  = lint_ADDR;
      wdata_d = lint_WDATA;
      wen_d   = lint_WEN;
      be_d    = lint_BE;
    end
  end

  // output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lint_REQ   <= 1'b0;
      lint_WEN   <= 1'b1;
      lint_ADDR  <= 20'd0;
      lint_BE    <= 4'd0;
      lint_WDATA <= 32'd0;
      prdata_o   <= 32'd0;
      pready_o   <= 1'b0;
      pslverr_o  <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      lint_REQ   <= req_d;
      lint_WEN   <= wen_d;
      lint_ADDR  <= addr_d;
      lint_BE    <= be_d;
      lint_WDATA <= wdata_d;
      prdata_o   <= prdata_d;
      pready_o   <= pready_d;
      pslverr_o  <= pslverr_d;
      timeout_o  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_efpga_lint_initiator.sv
// Directed bench: dut_a uses the default timeout, dut_b uses TIMEOUT_CYCLES=8; both share stimulus.
module tb_apb_efpga_lint_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite, fpga_ready, gnt, valid;
  logic [19:0] paddr;
  logic [31:0] pwdata, rdata;
  logic [3:0]  pstrb;

  logic [31:0] a_prdata, b_prdata, a_wdata, b_wdata;
  logic        a_pready, b_pready, a_pslverr, b_pslverr;
  logic [19:0] a_addr, b_addr;
  logic        a_wen, b_wen, a_req, b_req, a_timeout, b_timeout;
  logic [3:0]  a_be, b_be;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  apb_efpga_lint_initiator dut_a (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(a_prdata),
    .pready_o(a_pready), .pslverr_o(a_pslverr), .fpga_ready_i(fpga_ready),
    .lint_ADDR(a_addr), .lint_WEN(a_wen), .lint_REQ(a_req), .lint_BE(a_be),
    .lint_WDATA(a_wdata), .lint_RDATA(rdata), .lint_GNT(gnt), .lint_VALID(valid),
    .timeout_o(a_timeout)
  );

  apb_efpga_lint_initiator #(.TIMEOUT_CYCLES(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(b_prdata),
    .pready_o(b_pready), .pslverr_o(b_pslverr), .fpga_ready_i(fpga_ready),
    .lint_ADDR(b_addr), .lint_WEN(b_wen), .lint_REQ(b_req), .lint_BE(b_be),
    .lint_WDATA(b_wdata), .lint_RDATA(rdata), .lint_GNT(gnt), .lint_VALID(valid),
    .timeout_o(b_timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_idle();
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  // setup phase, then access phase (cycle 0); returns in cycle 1
  task automatic apb_access(input logic w, input logic [19:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    step();
    penable = 1'b1;
    step();
  endtask

  task automatic do_reset();
    apb_idle(); gnt = 1'b0; valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 20'd0;
    pwdata = 32'd0; pstrb = 4'd0; fpga_ready = 1'b1; gnt = 1'b0; valid = 1'b0; rdata = 32'd0;
    step(); step();
    check_val("rst_req",     {31'd0, a_req},     32'd0);
    check_val("rst_wen",     {31'd0, a_wen},     32'd1);
    check_val("rst_addr",    {12'd0, a_addr},    32'd0);
    check_val("rst_be",      {28'd0, a_be},      32'd0);
    check_val("rst_wdata",   a_wdata,            32'd0);
    check_val("rst_prdata",  a_prdata,           32'd0);
    check_val("rst_pready",  {31'd0, a_pready},  32'd0);
    check_val("rst_pslverr", {31'd0, a_pslverr}, 32'd0);
    check_val("rst_timeout", {31'd0, a_timeout}, 32'd0);
    rst_n = 1'b1;
    step();

    // write with immediate grant and response
    apb_access(1'b1, 20'h00040, 32'hA5A5_1234, 4'b0011);
    check_val("wr_req",    {31'd0, a_req},    32'd1);
    check_val("wr_wen",    {31'd0, a_wen},    32'd0);
    check_val("wr_be",     {28'd0, a_be},     32'h3);
    check_val("wr_addr",   {12'd0, a_addr},   32'h40);
    check_val("wr_wdata",  a_wdata,           32'hA5A5_1234);
    check_val("wr_rdy_c1", {31'd0, a_pready}, 32'd0);
    gnt = 1'b1;
    step();
    check_val("wr_req_c2", {31'd0, a_req},    32'd0);
    check_val("wr_rdy_c2", {31'd0, a_pready}, 32'd0);
    gnt = 1'b0; valid = 1'b1;
    step();
    check_val("wr_rdy_c3", {31'd0, a_pready},  32'd1);
    check_val("wr_err",    {31'd0, a_pslverr}, 32'd0);
    check_val("wr_prdata", a_prdata,           32'd0);
    valid = 1'b0; apb_idle();
    step();
    check_val("wr_rdy_c4", {31'd0, a_pready}, 32'd0);

    // read with late grant; VALID during REQ must be ignored
    apb_access(1'b0, 20'hFFFFC, 32'd0, 4'b0000);
    check_val("rd_be",  {28'd0, a_be},  32'hF);
    check_val("rd_wen", {31'd0, a_wen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_val("rd_req_hold",  {31'd0, a_req},  32'd1);
      check_val("rd_addr_hold", {12'd0, a_addr}, 32'hFFFFC);
      check_val("rd_rdy_hold",  {31'd0, a_pready}, 32'd0);
      valid = (i == 1);
      step();
    end
    check_val("rd_req_c6", {31'd0, a_req}, 32'd1);
    gnt = 1'b1;
    step();
    check_val("rd_req_c7", {31'd0, a_req},    32'd0);
    check_val("rd_rdy_c7", {31'd0, a_pready}, 32'd0);
    gnt = 1'b0;
    step();
    valid = 1'b1; rdata = 32'h1234_5678;
    step();
    check_val("rd_rdy",    {31'd0, a_pready},  32'd1);
    check_val("rd_prdata", a_prdata,           32'h1234_5678);
    check_val("rd_err",    {31'd0, a_pslverr}, 32'd0);
    valid = 1'b0; apb_idle();
    step();
    check_val("rd_prdata_clr", a_prdata,          32'd0);
    check_val("rd_rdy_clr",    {31'd0, a_pready}, 32'd0);

    // eFPGA not ready: immediate error
    fpga_ready = 1'b0;
    apb_access(1'b0, 20'h00100, 32'd0, 4'b0000);
    check_val("nr_rdy",    {31'd0, a_pready},  32'd1);
    check_val("nr_err",    {31'd0, a_pslverr}, 32'd1);
    check_val("nr_prdata", a_prdata,           32'hDEAD_BEEF);
    check_val("nr_req",    {31'd0, a_req},     32'd0);
    apb_idle(); fpga_ready = 1'b1;
    step();
    check_val("nr_rdy_clr", {31'd0, a_pready},  32'd0);
    check_val("nr_err_clr", {31'd0, a_pslverr}, 32'd0);
    check_val("nr_prd_clr", a_prdata,           32'd0);

    // timeout without grant (dut_b)
    do_reset();
    apb_access(1'b0, 20'h00200, 32'd0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      check_val("to_req_hold", {31'd0, b_req},     32'd1);
      check_val("to_tmo_low",  {31'd0, b_timeout}, 32'd0);
      step();
    end
    check_val("to_req_drop", {31'd0, b_req},     32'd0);
    check_val("to_pulse",    {31'd0, b_timeout}, 32'd1);
    check_val("to_rdy",      {31'd0, b_pready},  32'd1);
    check_val("to_err",      {31'd0, b_pslverr}, 32'd1);
    check_val("to_prdata",   b_prdata,           32'hDEAD_BEEF);
    apb_idle();
    step();
    check_val("to_pulse_end", {31'd0, b_timeout}, 32'd0);
    check_val("to_rdy_end",   {31'd0, b_pready},  32'd0);

    // timeout after grant, then drain of the late response
    apb_access(1'b0, 20'h00300, 32'd0, 4'b0000);
    check_val("dr_req", {31'd0, b_req}, 32'd1);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    check_val("dr_req_c2", {31'd0, b_req}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      check_val("dr_rdy_wait", {31'd0, b_pready}, 32'd0);
      step();
    end
    check_val("dr_rdy",   {31'd0, b_pready},  32'd1);
    check_val("dr_err",   {31'd0, b_pslverr}, 32'd1);
    check_val("dr_pulse", {31'd0, b_timeout}, 32'd1);
    apb_idle();
    step();
    apb_access(1'b0, 20'h00304, 32'd0, 4'b0000);
    check_val("dr_wait_req", {31'd0, b_req},    32'd0);
    check_val("dr_wait_rdy", {31'd0, b_pready}, 32'd0);
    step();
    check_val("dr_wait_req2", {31'd0, b_req}, 32'd0);
    valid = 1'b1; rdata = 32'hBAD0_BAD0;
    step();
    valid = 1'b0;
    check_val("dr_then_req", {31'd0, b_req},     32'd1);
    check_val("dr_no_pulse", {31'd0, b_timeout}, 32'd0);
    check_val("dr_addr",     {12'd0, b_addr},    32'h00304);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    check_val("dr_req_off", {31'd0, b_req}, 32'd0);
    valid = 1'b1; rdata = 32'hCAFE_F00D;
    step();
    check_val("dr_fin_rdy",    {31'd0, b_pready},  32'd1);
    check_val("dr_fin_prdata", b_prdata,           32'hCAFE_F00D);
    check_val("dr_fin_err",    {31'd0, b_pslverr}, 32'd0);
    valid = 1'b0; apb_idle();
    step();

    // asynchronous reset while in RESP, then a clean write
    do_reset();
    apb_access(1'b1, 20'h00ABC, 32'h1111_2222, 4'hF);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    check_val("ar_pre_wen", {31'd0, a_wen}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_val("ar_req",    {31'd0, a_req},    32'd0);
    check_val("ar_wen",    {31'd0, a_wen},    32'd1);
    check_val("ar_addr",   {12'd0, a_addr},   32'd0);
    check_val("ar_be",     {28'd0, a_be},     32'd0);
    check_val("ar_wdata",  a_wdata,           32'd0);
    check_val("ar_pready", {31'd0, a_pready}, 32'd0);
    apb_idle();
    step();
    rst_n = 1'b1; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("ar_no_rdy", {31'd0, a_pready}, 32'd0);
      step();
    end
    apb_access(1'b1, 20'h00010, 32'h55AA_55AA, 4'b1100);
    check_val("ar2_req", {31'd0, a_req}, 32'd1);
    check_val("ar2_be",  {28'd0, a_be},  32'hC);
    gnt = 1'b1;
    step();
    gnt = 1'b0; valid = 1'b1;
    step();
    check_val("ar2_rdy", {31'd0, a_pready},  32'd1);
    check_val("ar2_err", {31'd0, a_pslverr}, 32'd0);
    valid = 1'b0; apb_idle();
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/apb_efpga_lint_initiator.md
APB_EFPGA_LINT_INITIATOR -- requirements
Module: apb_efpga_lint_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent in REQ+RESP or DRAIN before abort (range 2..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, meaning the PRDATA value returned on any errored read.
REQ-003 SHALL have ports:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write (1=write).
- paddr_i  in  20  APB address, forwarded verbatim.
- pwdata_i  in  32  APB write data.
- pstrb_i  in  4  APB byte strobes.
- prdata_o  out  32  APB read data.
- pready_o  out  1  APB ready.
- pslverr_o  out  1  APB error.
- fpga_ready_i  in  1  eFPGA configured and out of reset.
- lint_ADDR  out  20  lint address.
- lint_WEN  out  1  lint write enable, active-low (0=write).
- lint_REQ  out  1  lint request.
- lint_BE  out  4  lint byte enables.
- lint_WDATA  out  32  lint write data.
- lint_RDATA  in  32  lint read data.
- lint_GNT  in  1  lint grant.
- lint_VALID  in  1  lint response valid (reads and writes).
- timeout_o  out  1  one-cycle pulse per aborted transaction.

Function
REQ-004 SHALL implement FSM states IDLE, DRAIN, REQ, RESP, DONE; all outputs registered.
REQ-005 IDLE: on psel_i&penable_i, SHALL latch paddr_i, pwdata_i, pwrite_i, BE (pstrb_i for writes, 4'hF for reads); next state DONE with error if fpga_ready_i=0, else DRAIN if drain flag set, else REQ.
REQ-006 REQ: lint_REQ=1, lint_ADDR/WEN/BE/WDATA SHALL hold latched values unchanged until the cycle lint_GNT=1 is sampled; then lint_REQ=0 next cycle, state RESP.
REQ-007 RESP: lint_VALID sampled 1 SHALL capture lint_RDATA (reads only) and go to DONE with no error; lint_VALID in the grant cycle itself SHALL be ignored.
REQ-008 DONE: pready_o=1 for exactly one cycle, pslverr_o=error flag, prdata_o=captured data (reads, no error) / ERR_RDATA (errored reads) / 0 (writes); next state IDLE.
REQ-009 pready_o SHALL be 0 in every state other than DONE; prdata_o and pslverr_o SHALL return to 0 the cycle after DONE.
REQ-010 Timeout counter (16-bit) SHALL clear on entry to REQ or DRAIN and increment each cycle in REQ, RESP, DRAIN; reaching TIMEOUT_CYCLES SHALL force DONE with error and pulse timeout_o.
REQ-011 Timeout in REQ SHALL deassert lint_REQ next cycle with no drain; timeout in RESP (grant given, response owed) SHALL set drain flag.
REQ-012 Drain flag SHALL clear on any lint_VALID sampled in IDLE or DRAIN; DRAIN SHALL go to REQ on lint_VALID or timeout (drain cleared either way, timeout_o pulses, no APB error for that case).
REQ-013 lint_GNT while lint_REQ=0 SHALL be ignored; lint_VALID in REQ SHALL be ignored.
REQ-014 Minimum latency: access detected cycle 0, lint_REQ cycle 1, GNT in cycle 1, VALID cycle 2, pready_o cycle 3.
REQ-015 Only one lint transaction SHALL be outstanding; APB inputs are ignored outside IDLE.
REQ-016 fpga_ready_i SHALL be sampled only in IDLE; deassertion mid-transaction SHALL have no effect (timeout covers hangs).

Reset
REQ-017 rst_ni low SHALL asynchronously force IDLE, drain=0, counter=0, lint_REQ=0, lint_WEN=1, lint_ADDR=0, lint_BE=0, lint_WDATA=0, prdata_o=0, pready_o=0, pslverr_o=0, timeout_o=0.
REQ-018 Reset mid-transaction SHALL drop lint_REQ immediately; no pready_o after release until a new access.

Verification
REQ-019 Write 0x00040 data 0xA5A5_1234 pstrb 4'b0011, GNT immediate, VALID next cycle -> lint_WEN=0, BE=4'b0011, pready_o cycle 3, pslverr_o=0, prdata_o=0.
REQ-020 Read 0xFFFFC, GNT after 5 cycles (REQ/ADDR stable throughout), VALID 2 cycles later with 0x1234_5678 -> BE=4'hF, prdata_o=0x1234_5678, pslverr_o=0.
REQ-021 Read with fpga_ready_i=0 -> no lint_REQ, pready_o cycle 1, pslverr_o=1, prdata_o=0xDEAD_BEEF.
REQ-022 TIMEOUT_CYCLES=8, GNT never -> lint_REQ high 8 cycles then low, timeout_o pulse, pslverr_o=1.
REQ-023 TIMEOUT_CYCLES=8, GNT given, VALID withheld -> error; next read waits in DRAIN, late VALID consumed there, then normal REQ/response with correct data.
REQ-024 rst_ni asserted while in RESP -> all outputs at reset values same cycle; subsequent write completes normally.
